i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_if.sv | 27 ++
 rtl/i2s_rx.sv | 167 ++++++++++++++++
 tb/tb_i2s_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// rtl/i2s_rx_if.sv - stereo pair output stream of the I2S receiver.
// The producer holds left/right data stable while out_valid waits on out_ready.
interface i2s_rx_if #(
  parameter int SAMPLE_SIZE = 24
);
  logic [SAMPLE_SIZE-1:0] left_data;
  logic [SAMPLE_SIZE-1:0] right_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overrun;

  modport master (
    output left_data,
    output right_data,
    output out_valid,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  left_data,
    input  right_data,
    input  out_valid,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S slave receiver: oversampled bclk/wclk/sdata, deserializes
// left/right words and presents them as a valid/ready stereo pair.
module i2s_rx #(
  parameter int SAMPLE_SIZE = 24,
  parameter int WCLK_BITS   = 32,
  parameter int BIT_CNT_W   = 6
) (
  input  logic        adc_clk,
  input  logic        rst_n,
  input  logic        i2s_bclk,
  input  logic        i2s_wclk,
  input  logic        i2s_sdata,
  i2s_rx_if.master    out_if
);

  localparam logic [BIT_CNT_W-1:0] SS_CNT   = BIT_CNT_W'(SAMPLE_SIZE);
  localparam logic [BIT_CNT_W-1:0] SS_LAST  = BIT_CNT_W'(SAMPLE_SIZE - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(WCLK_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_ONE  = BIT_CNT_W'(1);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  logic [1:0]             bclk_sync;
  logic [1:0]             wclk_sync;
  logic [1:0]             sdata_sync;
  logic                   bclk_prev;

  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   channel;
  logic                   locked;
  logic                   left_ok;
  logic                   wclk_held;
  logic [SAMPLE_SIZE-1:0] shift_reg;
  logic [SAMPLE_SIZE-1:0] left_hold;
  logic [SAMPLE_SIZE-1:0] right_hold;
  logic                   pair_form;

  out_state_t             out_state;
  out_state_t             out_state_nxt;
  logic                   pair_load;
  logic                   pair_drop;
  logic [SAMPLE_SIZE-1:0] left_q;
  logic [SAMPLE_SIZE-1:0] right_q;
  logic                   overrun_q;

  logic                   wclk_s;
  logic                   sdata_s;
  logic                   bclk_rise;
  logic                   slot_start;
  logic                   capture;
  logic                   word_done;
  logic [SAMPLE_SIZE-1:0] word_next;

  // All three lines leave the synchronizer from the same stage so the
  // bclk-to-data relationship of the source is preserved.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync  <= 2'b00;
      wclk_sync  <= 2'b00;
      sdata_sync <= 2'b00;
      bclk_prev  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[0], i2s_bclk};
      wclk_sync  <= {wclk_sync[0], i2s_wclk};
      sdata_sync <= {sdata_sync[0], i2s_sdata};
      bclk_prev  <= bclk_sync[1];
    end
  end

  assign wclk_s     = wclk_sync[1];
  assign sdata_s    = sdata_sync[1];
  assign bclk_rise  = bclk_sync[1] & ~bclk_prev;
  assign slot_start = bclk_rise && (wclk_s != wclk_held);
  assign capture    = bclk_rise && !slot_start && locked && (bit_cnt < SS_CNT);
  assign word_done  = capture && (bit_cnt == SS_LAST);
  assign word_next  = {shift_reg[SAMPLE_SIZE-2:0], sdata_s};

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      channel    <= 1'b0;
      locked     <= 1'b0;
      left_ok    <= 1'b0;
      wclk_held  <= 1'b0;
      shift_reg  <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      pair_form  <= 1'b0;
    end else begin
      pair_form <= word_done && channel && left_ok;
      if (slot_start) begin
        // The first bit after a wclk edge is the I2S delay bit and is dropped.
        bit_cnt   <= '0;
        channel   <= wclk_s;
        wclk_held <= wclk_s;
        locked    <= 1'b1;
        if (locked && (bit_cnt < SS_CNT)) begin
          left_ok <= 1'b0;
        end
      end else if (bclk_rise && locked) begin
        if (capture) begin
          shift_reg <= word_next;
        end
        if (bit_cnt != CNT_LAST) begin
          bit_cnt <= bit_cnt + CNT_ONE;
        end
        if (word_done) begin
          if (!channel) begin
            left_hold <= word_next;
            left_ok   <= 1'b1;
          end else if (left_ok) begin
            right_hold <= word_next;
            left_ok    <= 1'b0;
          end
        end
      end
    end
  end

  // Output stage: EMPTY until a pair is loaded, FULL while it waits for ready.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= OUT_EMPTY;
    end else begin
      out_state <= out_state_nxt;
    end
  end

  always_comb begin
    out_state_nxt = out_state;
    case (out_state)
      OUT_EMPTY: if (pair_form) out_state_nxt = OUT_FULL;
      OUT_FULL:  if (out_if.out_ready && !pair_form) out_state_nxt = OUT_EMPTY;
      default:   out_state_nxt = OUT_EMPTY;
    endcase
  end

  always_comb begin
    out_if.out_valid = (out_state == OUT_FULL);
    pair_load = pair_form && ((out_state == OUT_EMPTY) || out_if.out_ready);
    pair_drop = pair_form && (out_state == OUT_FULL) && !out_if.out_ready;
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q    <= '0;
      right_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (pair_load) begin
        left_q  <= left_hold;
        right_q <= right_hold;
      end
      if (pair_drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out_if.left_data  = left_q;
  assign out_if.right_data = right_q;
  assign out_if.overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed bench for i2s_rx: table of stereo frames plus
// hand-written truncation, reset and backpressure sequences.
module tb_i2s_rx;

  logic adc_clk;
  logic rst_n;
  logic bclk;
  logic wclk;
  logic sdata;

  i2s_rx_if #(.SAMPLE_SIZE(24)) ifc ();

  i2s_rx #(
    .SAMPLE_SIZE(24),
    .WCLK_BITS  (32),
    .BIT_CNT_W  (6)
  ) dut (
    .adc_clk  (adc_clk),
    .rst_n    (rst_n),
    .i2s_bclk (bclk),
    .i2s_wclk (wclk),
    .i2s_sdata(sdata),
    .out_if   (ifc)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] got_l[$];
  logic [23:0] got_r[$];
  int          stable_err = 0;
  time         t_mark = 0;
  time         t_rise = 0;
  logic        ov_prev = 1'b0;
  logic        hold_prev = 1'b0;
  logic [23:0] l_prev = '0;
  logic [23:0] r_prev = '0;

  // Transfer and stability monitor, sampled mid-cycle.
  always @(negedge adc_clk) begin
    if (ifc.out_valid && ifc.out_ready) begin
      got_l.push_back(ifc.left_data);
      got_r.push_back(ifc.right_data);
    end
    if (ifc.out_valid && !ov_prev) t_rise = $time;
    if (hold_prev && ifc.out_valid &&
        ((ifc.left_data != l_prev) || (ifc.right_data != r_prev)))
      stable_err = stable_err + 1;
    hold_prev = ifc.out_valid && !ifc.out_ready;
    l_prev    = ifc.left_data;
    r_prev    = ifc.right_data;
    ov_prev   = ifc.out_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  // One bclk period: low 2 adc_clk (data/wclk change), high 2 adc_clk.
  task automatic bclk_bit(input logic w, input logic d, input bit mark);
    bclk  = 1'b0;
    wclk  = w;
    sdata = d;
    tick();
    tick();
    bclk = 1'b1;
    if (mark) t_mark = $time;
    tick();
    tick();
  endtask

  // Slot position 0 is the delay bit, 1..24 the word MSB first, the rest padding.
  task automatic send_slot(input logic w, input logic [23:0] word, input int nbits, input logic pad);
    logic d;
    for (int k = 0; k < nbits; k++) begin
      if (k >= 1 && k <= 24) d = word[24-k];
      else                   d = pad;
      bclk_bit(w, d, (k == 24) && w);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic pad);
    send_slot(1'b0, l, 32, pad);
    send_slot(1'b1, r, 32, pad);
  endtask

  task automatic check_one_pair(input string name, input logic [23:0] el, input logic [23:0] er);
    check({name, "_count"}, got_l.size(), 1);
    if (got_l.size() >= 1) begin
      check({name, "_left"},  {8'h0, got_l[0]}, {8'h0, el});
      check({name, "_right"}, {8'h0, got_r[0]}, {8'h0, er});
    end
    got_l.delete();
    got_r.delete();
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        pad;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{24'hA5C3F0, 24'h0F1E2D, 1'b0, 24'hA5C3F0, 24'h0F1E2D};
    vt[1] = '{24'h800001, 24'h7FFFFE, 1'b0, 24'h800001, 24'h7FFFFE};
    vt[2] = '{24'hFFFFFF, 24'h000000, 1'b0, 24'hFFFFFF, 24'h000000};
    vt[3] = '{24'h5A5A5A, 24'hC3C3C3, 1'b0, 24'h5A5A5A, 24'hC3C3C3};
    vt[4] = '{24'h000000, 24'hFFFFFF, 1'b1, 24'h000000, 24'hFFFFFF};
    vt[5] = '{24'h000001, 24'h800000, 1'b1, 24'h000001, 24'h800000};

    rst_n = 1'b0;
    bclk = 1'b0;
    wclk = 1'b0;
    sdata = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid",   {31'h0, ifc.out_valid}, 0);
    check("rst_overrun", {31'h0, ifc.overrun}, 0);
    check("rst_left",    {8'h0, ifc.left_data}, 0);
    check("rst_right",   {8'h0, ifc.right_data}, 0);
    rst_n = 1'b1;
    tick();

    // Left bits before the first wclk edge are ignored; the first right slot
    // only locks the receiver and has no left partner.
    send_slot(1'b0, 24'h777777, 32, 1'b0);
    send_slot(1'b1, 24'h999999, 32, 1'b0);
    check("unlocked_no_pair", got_l.size(), 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].l, vt[i].r, vt[i].pad);
      check_one_pair($sformatf("vec%0d", i), vt[i].el, vt[i].er);
      check($sformatf("vec%0d_latency", i),
            ((t_rise > t_mark) && (t_rise - t_mark <= 55)) ? 1 : 0, 1);
    end
    check("stream_overrun", {31'h0, ifc.overrun}, 0);

    // A short right slot kills the pending left word.
    send_slot(1'b0, 24'h111111, 32, 1'b0);
    send_slot(1'b1, 24'h2A2A2A, 10, 1'b0);
    send_slot(1'b0, 24'h3B3B3B, 10, 1'b0);
    send_slot(1'b1, 24'h222222, 32, 1'b0);
    check("short_right_no_pair", got_l.size(), 0);
    send_frame(24'h333333, 24'h444444, 1'b0);
    check_one_pair("after_short_right", 24'h333333, 24'h444444);

    send_slot(1'b0, 24'hABCDEF, 10, 1'b0);
    send_slot(1'b1, 24'hFEDCBA, 32, 1'b0);
    check("short_left_no_pair", got_l.size(), 0);
    send_frame(24'h0ABCDE, 24'h0FEDCB, 1'b0);
    check_one_pair("after_short_left", 24'h0ABCDE, 24'h0FEDCB);

    // Reset in the middle of a left slot clears outputs without a clock edge.
    send_slot(1'b0, 24'hDEADBE, 12, 1'b0);
    #2;
    rst_n = 1'b0;
    #2;
    check("async_rst_left",  {8'h0, ifc.left_data}, 0);
    check("async_rst_right", {8'h0, ifc.right_data}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    send_slot(1'b0, 24'hDEADBE, 20, 1'b0);
    send_slot(1'b1, 24'h5EED00, 32, 1'b0);
    check("midreset_no_pair", got_l.size(), 0);
    send_frame(24'h123456, 24'h654321, 1'b0);
    check_one_pair("after_reset", 24'h123456, 24'h654321);

    // Backpressure across two frames: first pair held, second dropped.
    ifc.out_ready = 1'b0;
    send_frame(24'hAAAAAA, 24'h555555, 1'b0);
    send_frame(24'h13579B, 24'h2468AC, 1'b0);
    check("bp_valid",   {31'h0, ifc.out_valid}, 1);
    check("bp_overrun", {31'h0, ifc.overrun}, 1);
    check("bp_left",    {8'h0, ifc.left_data}, 32'h00AAAAAA);
    check("bp_right",   {8'h0, ifc.right_data}, 32'h00555555);
    check("bp_stable",  stable_err, 0);
    check("bp_no_xfer", got_l.size(), 0);
    ifc.out_ready = 1'b1;
    tick();
    tick();
    check("bp_valid_drop", {31'h0, ifc.out_valid}, 0);
    check_one_pair("bp_release", 24'hAAAAAA, 24'h555555);

    send_frame(24'h0C0FFE, 24'h0BEEF0, 1'b0);
    check_one_pair("post_overrun", 24'h0C0FFE, 24'h0BEEF0);
    check("overrun_sticky", {31'h0, ifc.overrun}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
